store_merge_unit: RTL and testbench
===================================

Name: store_merge_unit

Overview:
- Parametrised sub-word store unit between the execute stage and the data memory port.
- Accepts byte/half/word(/dword) store requests and replicates store data into the correct byte lanes.
- Either drives byte enables directly or, for memories without byte enables, performs a read-modify-write sequence.
- Misaligned requests are rejected with an error response and no memory access.

Parameters:
- DATA_W, 32, memory data width in bits; 32 or 64 only. NLANES = DATA_W/8.
- ADDR_W, 32, byte-address width.
- RMW_EN, 1, 1 = read-modify-write, mem_be tied all-ones; 0 = single write using mem_be.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit idle, request accepted on valid&&ready
- req_addr  in  ADDR_W  byte address
- req_data  in  DATA_W  store data, LSB-justified
- req_size  in  2  size_t: 0 byte, 1 half, 2 word, 3 dword
- resp_done  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_done; 1 = misaligned or illegal size
- mem_addr  out  ADDR_W  word-aligned address (low log2(NLANES) bits zero)
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_be  out  NLANES  byte enables
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid when mem_rd && !mem_busy
- mem_busy  in  1  memory stall; a strobe completes in the first cycle it is high with mem_busy low

Behaviour:
- Reset (async, nrst low): state IDLE; all registers cleared; req_ready=1; resp_done, resp_err, mem_rd, mem_wr = 0; mem_addr, mem_wdata = 0; mem_be = 0. Strobes drop immediately on reset mid-transaction; the in-flight store is abandoned with no response.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On accept, register address, size, data, and alignment check.
  - Error: size 3 when DATA_W=32; half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0. Error -> RESP with err=1, no strobe.
  - Else if RMW_EN and the store is not full-width -> READ; otherwise -> WRITE.
- READ: mem_rd=1, mem_addr held. On !mem_busy, capture mem_rdata -> WRITE.
- WRITE: mem_wr=1 and mem_wdata held stable until !mem_busy -> RESP.
  - RMW_EN=1: mem_wdata = (rdata_q & ~mask) | (shifted & mask); mem_be all-ones.
  - RMW_EN=0: mem_wdata = shifted; mem_be = lane mask.
- RESP: resp_done=1 for exactly one cycle, resp_err valid; req_ready=0 -> IDLE.
- Strobes: mem_rd and mem_wr are never high together. Strobes, mem_addr, mem_be, and mem_wdata are registered outputs (Moore).
- Lane math (lane = addr mod NLANES):
  - byte: shifted = req_data[7:0] << 8*lane; mask = 0xFF << 8*lane.
  - half: shifted = req_data[15:0] << 8*lane; mask = 0xFFFF << 8*lane.
  - word: shifted = req_data[31:0] << 8*lane; mask = 0xFFFFFFFF << 8*lane.
  - dword: shifted = req_data[63:0]; mask = all ones.
  - Upper req_data bits beyond the size are ignored.
- Latency from accept to resp_done:
  - full-width or RMW_EN=0: 2 cycles;
  - RMW: 3 cycles;
  - error: 1 cycle;
  - plus one cycle per mem_busy stall cycle.
- req_valid while busy is ignored, with no queuing. The requester holds the request until ready.

Decomposition:
- store_pkg: size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD), state_t enum, function lane_mask(size, lane, NLANES).
- Sub-module store_lane_align, purely combinational: inputs data, size, lane; outputs shifted data, byte mask, misalign flag. Instantiated once; reused by the load path later.

Test Plan:
- Byte store, RMW_EN=0, DATA_W=32: addr 0x1003, data 0x0000_00AB -> mem_addr 0x1000, mem_be 4'b1000, mem_wdata 0xAB00_0000, resp_done 2 cycles after accept, err 0.
- Byte RMW, RMW_EN=1: addr 0x2001, data 0x5A; mem_rdata 0x1122_3344 -> mem_rd one cycle, then mem_wr with wdata 0x1122_5A44 and be 4'hF; done 3 cycles after accept.
- Half misaligned: addr 0x3003, size half -> resp_done with resp_err=1 one cycle after accept; mem_rd and mem_wr never asserted.
- mem_busy stall: word store at 0x4000 with mem_busy high 3 cycles -> mem_wr and mem_wdata stable for 4 cycles; done one cycle after busy drops.
- Async reset mid-READ: nrst low while mem_rd=1 -> mem_rd drops without a clock edge, no resp_done; after release req_ready=1.
- DATA_W=64, RMW_EN=0: half at addr 0x06, data 0xBEEF -> mem_be 8'b1100_0000, mem_wdata 0xBEEF_0000_0000_0000; size dword at addr 0x08 -> be 8'hFF, no error.

Source files
------------

// File: rtl/store_merge_unit_pkg.sv
// rtl/store_merge_unit_pkg.sv - shared types and lane helpers for the store merge unit
package store_merge_unit_pkg;

  localparam int MAX_LANES = 8;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Byte-lane enable pattern for a store of the given size starting at lane.
  // Lanes at or above nlanes are cleared so narrow memories never see them.
  function automatic logic [MAX_LANES-1:0] lane_mask(size_t size, logic [2:0] lane, int nlanes);
    logic [MAX_LANES-1:0] m;
    unique case (size)
      SZ_BYTE: m = 8'h01 << lane;
      SZ_HALF: m = 8'h03 << lane;
      SZ_WORD: m = 8'h0F << lane;
      default: m = 8'hFF;
    endcase
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i >= nlanes) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// rtl/store_merge_unit_if.sv - request/response and memory port bundle for the store merge unit
interface store_merge_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NLANES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;
  logic              resp_done;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [NLANES-1:0] mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_busy;

  // Store unit side: accepts requests, drives the memory strobes.
  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_busy,
    output req_ready, resp_done, resp_err, mem_addr, mem_rd, mem_wr, mem_be, mem_wdata
  );

  // Environment side: execute stage plus data memory.
  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata, mem_busy,
    input  req_ready, resp_done, resp_err, mem_addr, mem_rd, mem_wr, mem_be, mem_wdata
  );
endinterface

// File: rtl/store_merge_unit_lane_align.sv
// rtl/store_merge_unit_lane_align.sv - combinational sub-word lane placement and alignment check
module store_lane_align
  import store_merge_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NLANES = DATA_W / 8,
  parameter int LANE_W = $clog2(NLANES)
) (
  input  logic [DATA_W-1:0] data_i,
  input  size_t             size_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [DATA_W-1:0] shifted_o,
  output logic [NLANES-1:0] mask_o,
  output logic              misalign_o
);

  logic [DATA_W-1:0] sized;

  // Drop data bits above the access size, then move the payload up to its lane
  always_comb begin
    sized = '0;
    unique case (size_i)
      SZ_BYTE: sized[7:0]  = data_i[7:0];
      SZ_HALF: sized[15:0] = data_i[15:0];
      SZ_WORD: sized[31:0] = data_i[31:0];
      default: sized       = data_i;
    endcase
    if (size_i == SZ_DWORD) begin
      shifted_o = sized;
    end else begin
      shifted_o = sized << {lane_i, 3'b000};
    end
  end

  assign mask_o = NLANES'(lane_mask(size_i, 3'(lane_i), NLANES));

  // Natural alignment; a dword on a 32-bit memory is an illegal size
  always_comb begin
    unique case (size_i)
      SZ_BYTE: misalign_o = 1'b0;
      SZ_HALF: misalign_o = lane_i[0];
      SZ_WORD: misalign_o = |lane_i[1:0];
      default: misalign_o = (NLANES < 8) ? 1'b1 : (|lane_i);
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - sub-word store unit with byte-enable or read-modify-write memory access
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter bit RMW_EN = 1'b1
) (
  input logic               clk,
  input logic               nrst,
  store_merge_unit_if.slave bus
);

  localparam int NLANES = DATA_W / 8;
  localparam int LANE_W = $clog2(NLANES);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shifted_q;
  logic [NLANES-1:0] bmask_q;
  logic              err_q;

  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              resp_done_q, resp_done_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NLANES-1:0] mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [DATA_W-1:0] al_shifted;
  logic [NLANES-1:0] al_mask;
  logic              al_misalign;
  logic              accept;
  logic [ADDR_W-1:0] addr_aligned;
  logic [DATA_W-1:0] bitmask;
  logic [DATA_W-1:0] merged;

  store_lane_align #(
    .DATA_W (DATA_W),
    .NLANES (NLANES),
    .LANE_W (LANE_W)
  ) u_align (
    .data_i     (bus.req_data),
    .size_i     (size_t'(bus.req_size)),
    .lane_i     (bus.req_addr[LANE_W-1:0]),
    .shifted_o  (al_shifted),
    .mask_o     (al_mask),
    .misalign_o (al_misalign)
  );

  assign accept       = (state_q == ST_IDLE) && bus.req_valid;
  assign addr_aligned = {bus.req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};

  // Widen the captured byte mask to a bit mask for the read-modify-write merge
  always_comb begin
    bitmask = '0;
    for (int i = 0; i < NLANES; i++) begin
      bitmask[8*i +: 8] = {8{bmask_q[i]}};
    end
  end

  assign merged = (bus.mem_rdata & ~bitmask) | (shifted_q & bitmask);

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: errors skip memory, partial stores read first when RMW is enabled
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (al_misalign) begin
            state_d = ST_RESP;
          end else if (RMW_EN && !(&al_mask)) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_READ:  if (!bus.mem_busy) state_d = ST_WRITE;
      ST_WRITE: if (!bus.mem_busy) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next-values, decoded from the upcoming state so every output is a flop
  always_comb begin
    mem_rd_d    = (state_d == ST_READ);
    mem_wr_d    = (state_d == ST_WRITE);
    resp_done_d = (state_d == ST_RESP);
    resp_err_d  = (state_d == ST_RESP) && (accept ? al_misalign : err_q);

    mem_addr_d = mem_addr_q;
    if (accept && !al_misalign) begin
      mem_addr_d = addr_aligned;
    end

    mem_wdata_d = mem_wdata_q;
    if (accept && (state_d == ST_WRITE)) begin
      mem_wdata_d = al_shifted;
    end else if ((state_q == ST_READ) && (state_d == ST_WRITE)) begin
      mem_wdata_d = merged;
    end

    mem_be_d = '0;
    if ((state_d == ST_READ) || (state_d == ST_WRITE)) begin
      if (RMW_EN) begin
        mem_be_d = '1;
      end else if (accept) begin
        mem_be_d = al_mask;
      end else begin
        mem_be_d = mem_be_q;
      end
    end
  end

  // Request capture: lane-placed data, byte mask and alignment verdict
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shifted_q <= '0;
      bmask_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      shifted_q <= al_shifted;
      bmask_q   <= al_mask;
      err_q     <= al_misalign;
    end
  end

  // Registered outputs; reset drops strobes immediately and abandons the store
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      resp_done_q <= 1'b0;
      resp_err_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      resp_done_q <= resp_done_d;
      resp_err_q  <= resp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.resp_done = resp_done_q;
  assign bus.resp_err  = resp_err_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - self-checking bench for three store_merge_unit configurations
module tb_store_merge_unit;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 32-bit byte enables, 1: 32-bit RMW, 2: 64-bit byte enables
  logic [2:0]  req_valid;
  logic [2:0]  mem_busy;
  logic [31:0] req_addr  [3];
  logic [63:0] req_data  [3];
  logic [1:0]  req_size  [3];
  logic [63:0] mem_rdata [3];

  logic [2:0]  o_ready, o_rd, o_wr, o_done, o_err;
  logic [31:0] o_addr  [3];
  logic [7:0]  o_be    [3];
  logic [63:0] o_wdata [3];

  int n_pass  = 0;
  int n_total = 0;

  store_merge_unit_if #(.DATA_W(32), .ADDR_W(32)) b0 ();
  store_merge_unit_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
  store_merge_unit_if #(.DATA_W(64), .ADDR_W(32)) b2 ();

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RMW_EN(1'b0)) u0 (.clk(clk), .nrst(nrst), .bus(b0));
  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .RMW_EN(1'b1)) u1 (.clk(clk), .nrst(nrst), .bus(b1));
  store_merge_unit #(.DATA_W(64), .ADDR_W(32), .RMW_EN(1'b0)) u2 (.clk(clk), .nrst(nrst), .bus(b2));

  assign b0.req_valid = req_valid[0];
  assign b0.req_addr  = req_addr[0];
  assign b0.req_data  = req_data[0][31:0];
  assign b0.req_size  = req_size[0];
  assign b0.mem_rdata = mem_rdata[0][31:0];
  assign b0.mem_busy  = mem_busy[0];
  assign b1.req_valid = req_valid[1];
  assign b1.req_addr  = req_addr[1];
  assign b1.req_data  = req_data[1][31:0];
  assign b1.req_size  = req_size[1];
  assign b1.mem_rdata = mem_rdata[1][31:0];
  assign b1.mem_busy  = mem_busy[1];
  assign b2.req_valid = req_valid[2];
  assign b2.req_addr  = req_addr[2];
  assign b2.req_data  = req_data[2];
  assign b2.req_size  = req_size[2];
  assign b2.mem_rdata = mem_rdata[2];
  assign b2.mem_busy  = mem_busy[2];

  assign o_ready  = {b2.req_ready, b1.req_ready, b0.req_ready};
  assign o_rd     = {b2.mem_rd, b1.mem_rd, b0.mem_rd};
  assign o_wr     = {b2.mem_wr, b1.mem_wr, b0.mem_wr};
  assign o_done   = {b2.resp_done, b1.resp_done, b0.resp_done};
  assign o_err    = {b2.resp_err, b1.resp_err, b0.resp_err};
  assign o_addr[0]  = b0.mem_addr;
  assign o_addr[1]  = b1.mem_addr;
  assign o_addr[2]  = b2.mem_addr;
  assign o_be[0]    = {4'b0, b0.mem_be};
  assign o_be[1]    = {4'b0, b1.mem_be};
  assign o_be[2]    = b2.mem_be;
  assign o_wdata[0] = {32'b0, b0.mem_wdata};
  assign o_wdata[1] = {32'b0, b1.mem_wdata};
  assign o_wdata[2] = b2.mem_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int nl_of(input int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic bit rmw_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic [63:0] full_of(input int nl);
    return (nl == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // What a store must do, from size/address arithmetic alone
  typedef struct packed {
    logic        err;
    logic        need_rd;
    logic [31:0] addr;
    logic [63:0] sh;
    logic [63:0] bm;
    logic [7:0]  be;
  } pred_t;

  function automatic pred_t predict(input int nl, input logic [31:0] a, input logic [63:0] d,
                                    input logic [1:0] sz);
    pred_t p;
    int nb, lane, be_i;
    logic [63:0] keep;
    nb   = 1 << sz;
    lane = int'(a % nl);
    keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    p.err     = (nb > nl) || ((a % nb) != 0);
    p.need_rd = (nb != nl);
    p.addr    = a - lane;
    p.sh      = ((d & keep) << (8 * lane)) & full_of(nl);
    p.bm      = (keep << (8 * lane)) & full_of(nl);
    be_i      = ((1 << nb) - 1) << lane;
    p.be      = be_i[7:0];
    if (nl == 4) p.be[7:4] = 4'b0;
    return p;
  endfunction

  // Reference model: phase 0 idle, 1 reading, 2 writing, 3 responding
  int          m_ph [3];
  pred_t       m_p  [3];
  logic [63:0] m_wd [3];
  pred_t       pnow [3];

  always_comb begin
    for (int i = 0; i < 3; i++) pnow[i] = predict(nl_of(i), req_addr[i], req_data[i], req_size[i]);
  end

  always @(posedge clk or negedge nrst) begin
    for (int i = 0; i < 3; i++) begin
      if (!nrst) begin
        m_ph[i] <= 0;
        m_wd[i] <= '0;
      end else begin
        case (m_ph[i])
          0: if (req_valid[i]) begin
            m_p[i]  <= pnow[i];
            m_wd[i] <= pnow[i].sh;
            m_ph[i] <= pnow[i].err ? 3 : ((rmw_of(i) && pnow[i].need_rd) ? 1 : 2);
          end
          1: if (!mem_busy[i]) begin
            m_wd[i] <= ((mem_rdata[i] & ~m_p[i].bm) | (m_p[i].sh & m_p[i].bm)) & full_of(nl_of(i));
            m_ph[i] <= 2;
          end
          2: if (!mem_busy[i]) m_ph[i] <= 3;
          default: m_ph[i] <= 0;
        endcase
      end
    end
  end

  // Cycle compare of every instance against the model
  always @(negedge clk) begin
    if (nrst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("d%0d req_ready", i), 64'(o_ready[i]), 64'(m_ph[i] == 0));
        chk($sformatf("d%0d mem_rd", i), 64'(o_rd[i]), 64'(m_ph[i] == 1));
        chk($sformatf("d%0d mem_wr", i), 64'(o_wr[i]), 64'(m_ph[i] == 2));
        chk($sformatf("d%0d resp_done", i), 64'(o_done[i]), 64'(m_ph[i] == 3));
        if (m_ph[i] == 3) chk($sformatf("d%0d resp_err", i), 64'(o_err[i]), 64'(m_p[i].err));
        if (m_ph[i] == 1 || m_ph[i] == 2)
          chk($sformatf("d%0d mem_addr", i), 64'(o_addr[i]), 64'(m_p[i].addr));
        if (m_ph[i] == 2) begin
          chk($sformatf("d%0d mem_wdata", i), o_wdata[i], m_wd[i]);
          chk($sformatf("d%0d mem_be", i), 64'(o_be[i]),
              rmw_of(i) ? 64'(full_of(nl_of(i)) == 64'hFFFF_FFFF_FFFF_FFFF ? 8'hFF : 8'h0F)
                        : 64'(m_p[i].be));
        end
      end
    end
  end

  // Drive one request, hold it until taken, and record what the memory port did
  task automatic issue(input int i, input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz,
                       input int stall, output int lat, output int nrd, output int nwr,
                       output logic err, output logic [31:0] wa, output logic [7:0] wbe,
                       output logic [63:0] wd, output logic stable);
    int guard;
    @(negedge clk);
    req_addr[i] = a; req_data[i] = d; req_size[i] = sz; req_valid[i] = 1'b1;
    mem_busy[i] = (stall > 0);
    guard = 0;
    while (!o_ready[i] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("d%0d ready before accept", i), 64'(o_ready[i]), 64'd1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    lat = 0; nrd = 0; nwr = 0; err = 1'b0; wa = '0; wbe = '0; wd = '0; stable = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (o_rd[i]) nrd++;
      if (o_wr[i]) begin
        if (nwr > 0 && o_wdata[i] !== wd) stable = 1'b0;
        nwr++;
        wa = o_addr[i]; wbe = o_be[i]; wd = o_wdata[i];
        mem_busy[i] = (nwr <= stall);
      end
      if (o_done[i]) begin
        err = o_err[i];
        break;
      end
    end
    mem_busy[i] = 1'b0;
  endtask

  task automatic expect_txn(input string tag, input int i, input logic [31:0] a, input logic [63:0] d,
                            input logic [1:0] sz, input int stall, input int e_lat, input int e_rd,
                            input int e_wr, input logic e_err, input logic [31:0] e_wa,
                            input logic [7:0] e_be, input logic [63:0] e_wd);
    int lat, nrd, nwr;
    logic err, stable;
    logic [31:0] wa;
    logic [7:0] wbe;
    logic [63:0] wd;
    issue(i, a, d, sz, stall, lat, nrd, nwr, err, wa, wbe, wd, stable);
    chk({tag, " latency"}, 64'(lat), 64'(e_lat));
    chk({tag, " read cycles"}, 64'(nrd), 64'(e_rd));
    chk({tag, " write cycles"}, 64'(nwr), 64'(e_wr));
    chk({tag, " err"}, 64'(err), 64'(e_err));
    if (e_wr > 0) begin
      chk({tag, " mem_addr"}, 64'(wa), 64'(e_wa));
      chk({tag, " mem_be"}, 64'(wbe), 64'(e_be));
      chk({tag, " mem_wdata"}, wd, e_wd);
      chk({tag, " wdata stable"}, 64'(stable), 64'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    mem_busy  = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = '0; req_data[i] = '0; req_size[i] = '0; mem_rdata[i] = '0;
    end

    // Model pinned to hand-worked lane math
    chk("model byte shift", predict(4, 32'h1003, 64'hAB, 2'd0).sh, 64'hAB00_0000);
    chk("model half be 64", 64'(predict(8, 32'h6, 64'hBEEF, 2'd1).be), 64'hC0);
    chk("model dword on 32 err", 64'(predict(4, 32'h0, 64'h1, 2'd3).err), 64'd1);

    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset d%0d ready", i), 64'(o_ready[i]), 64'd1);
      chk($sformatf("reset d%0d strobes", i), 64'({o_rd[i], o_wr[i], o_done[i], o_err[i]}), 64'd0);
      chk($sformatf("reset d%0d addr/be/wdata", i), 64'(o_addr[i]) | 64'(o_be[i]) | o_wdata[i], 64'd0);
    end
    @(posedge clk);
    #2 nrst = 1'b1;

    expect_txn("byte be", 0, 32'h1003, 64'h0000_00AB, 2'd0, 0, 2, 0, 1, 1'b0, 32'h1000, 8'h08, 64'hAB00_0000);
    expect_txn("byte upper ignored", 0, 32'h1001, 64'hFFFF_FF12, 2'd0, 0, 2, 0, 1, 1'b0, 32'h1000, 8'h02, 64'h0000_1200);
    expect_txn("half misaligned", 0, 32'h3003, 64'h1234, 2'd1, 0, 1, 0, 0, 1'b1, 32'h0, 8'h0, 64'h0);
    expect_txn("word misaligned", 0, 32'h4002, 64'h1234, 2'd2, 0, 1, 0, 0, 1'b1, 32'h0, 8'h0, 64'h0);
    expect_txn("dword on 32", 0, 32'h4000, 64'h1, 2'd3, 0, 1, 0, 0, 1'b1, 32'h0, 8'h0, 64'h0);
    expect_txn("word stall", 0, 32'h4000, 64'hDEAD_BEEF, 2'd2, 3, 5, 0, 4, 1'b0, 32'h4000, 8'h0F, 64'hDEAD_BEEF);

    mem_rdata[1] = 64'h1122_3344;
    expect_txn("byte rmw", 1, 32'h2001, 64'h5A, 2'd0, 0, 3, 1, 1, 1'b0, 32'h2000, 8'h0F, 64'h1122_5A44);
    expect_txn("half rmw", 1, 32'h2002, 64'h1234, 2'd1, 0, 3, 1, 1, 1'b0, 32'h2000, 8'h0F, 64'h1234_3344);
    expect_txn("word rmw full", 1, 32'h2004, 64'hCAFE_F00D, 2'd2, 0, 2, 0, 1, 1'b0, 32'h2004, 8'h0F, 64'hCAFE_F00D);
    expect_txn("half rmw misaligned", 1, 32'h3003, 64'h1234, 2'd1, 0, 1, 0, 0, 1'b1, 32'h0, 8'h0, 64'h0);

    expect_txn("half 64", 2, 32'h0006, 64'hBEEF, 2'd1, 0, 2, 0, 1, 1'b0, 32'h0, 8'hC0, 64'hBEEF_0000_0000_0000);
    expect_txn("dword 64", 2, 32'h0008, 64'h0123_4567_89AB_CDEF, 2'd3, 0, 2, 0, 1, 1'b0, 32'h8, 8'hFF, 64'h0123_4567_89AB_CDEF);
    expect_txn("word lane4 64", 2, 32'h000C, 64'hCAFE_F00D, 2'd2, 0, 2, 0, 1, 1'b0, 32'h8, 8'hF0, 64'hCAFE_F00D_0000_0000);
    expect_txn("dword misaligned 64", 2, 32'h0004, 64'h1, 2'd3, 0, 1, 0, 0, 1'b1, 32'h0, 8'h0, 64'h0);

    // Asynchronous reset while the RMW instance is stalled in its read
    @(negedge clk);
    mem_busy[1] = 1'b1;
    req_addr[1] = 32'h2001; req_data[1] = 64'h5A; req_size[1] = 2'd0; req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rst mid-read mem_rd before", 64'(o_rd[1]), 64'd1);
    #3 nrst = 1'b0;
    #1;
    chk("rst mid-read mem_rd dropped", 64'(o_rd[1]), 64'd0);
    chk("rst mid-read no done", 64'({o_wr[1], o_done[1]}), 64'd0);
    chk("rst mid-read addr cleared", 64'(o_addr[1]), 64'd0);
    chk("rst mid-read ready", 64'(o_ready[1]), 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("rst held no done", 64'(o_done[1]), 64'd0);
    end
    @(posedge clk);
    #2 nrst = 1'b1;
    mem_busy[1] = 1'b0;
    @(negedge clk);
    chk("after reset ready", 64'(o_ready[1]), 64'd1);
    chk("after reset no done", 64'(o_done[1]), 64'd0);

    expect_txn("byte rmw after reset", 1, 32'h2003, 64'h77, 2'd0, 0, 3, 1, 1, 1'b0, 32'h2000, 8'h0F, 64'h7722_3344);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
